regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 11 +
 rtl/rr_picker.sv | 28 ++
 rtl/regfile_write_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_pkg;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 8;

  typedef logic [ADDR_W-1:0] regAddr_t;
  typedef logic [DATA_W-1:0] regData_t;

  typedef enum logic [1:0] {IDLE, ISSUE, LOCKED} arbState_t;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid requester at or after ptr.
module rr_picker #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [1:0]         ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         grant_idx
);
  int   j;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (en && !found && valid[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = 2'(j);
      end
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, 1-cycle registered output.
// Optional burst lock behind macro REGFILE_ARB_LOCK_EN.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = regfile_pkg::ADDR_W,
  parameter int DATA_W  = regfile_pkg::DATA_W
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        reqValid,
  input  logic [NUM_REQ*ADDR_W-1:0] reqAddr,
  input  logic [NUM_REQ*DATA_W-1:0] reqData,
  input  logic [NUM_REQ-1:0]        reqLock,
  output logic [NUM_REQ-1:0]        reqReady,
  output logic                      regWrite,
  output logic [ADDR_W-1:0]         writeRegister,
  output logic [DATA_W-1:0]         writeData,
  output logic [1:0]                grantId,
  output logic                      busy
);
  arbState_t           state, state_nxt;
  logic [NUM_REQ-1:0]  pick_valid, grant;
  logic [1:0]          grant_idx, rr_ptr, gnt_id;
  logic                pick_en, fire, wr_en;
  logic [ADDR_W-1:0]   sel_addr, wr_addr;
  logic [DATA_W-1:0]   sel_data, wr_data;

  function automatic logic [1:0] inc_ptr(input logic [1:0] i);
    return (int'(i) >= NUM_REQ-1) ? 2'd0 : i + 2'd1;
  endfunction

`ifdef REGFILE_ARB_LOCK_EN
  logic [1:0] owner;
  logic       owner_valid;
  assign owner_valid = reqValid[owner];

  // While locked only the owner is visible to the picker.
  always_comb begin
    pick_valid = reqValid;
    if (state == LOCKED) begin
      pick_valid        = '0;
      pick_valid[owner] = reqValid[owner];
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^reqLock;
  assign pick_valid  = reqValid;
`endif

  // Gating with resetN keeps reqReady low for the whole reset window.
  assign pick_en = resetN & ~hold;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid     (pick_valid),
    .ptr       (rr_ptr),
    .en        (pick_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign reqReady = grant;
  assign fire     = |grant;
  assign sel_addr = reqAddr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_data = reqData[int'(grant_idx)*DATA_W +: DATA_W];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
`ifdef REGFILE_ARB_LOCK_EN
    case (state)
      LOCKED: begin
        if (fire)              state_nxt = reqLock[grant_idx] ? LOCKED : ISSUE;
        else if (!owner_valid) state_nxt = IDLE;
      end
      default: begin
        if (fire) state_nxt = reqLock[grant_idx] ? LOCKED : ISSUE;
        else      state_nxt = IDLE;
      end
    endcase
`else
    state_nxt = fire ? ISSUE : IDLE;
`endif
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      gnt_id  <= '0;
      rr_ptr  <= '0;
`ifdef REGFILE_ARB_LOCK_EN
      owner   <= '0;
`endif
    end else begin
      wr_en <= fire;
      if (fire) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
        gnt_id  <= grant_idx;
      end
`ifdef REGFILE_ARB_LOCK_EN
      // rrPtr is frozen for the whole burst and advances past the owner when it ends.
      if (state == LOCKED) begin
        if ((fire && !reqLock[grant_idx]) || (!fire && !owner_valid))
          rr_ptr <= inc_ptr(owner);
      end else if (fire) begin
        owner <= grant_idx;
        if (!reqLock[grant_idx]) rr_ptr <= inc_ptr(grant_idx);
      end
`else
      if (fire) rr_ptr <= inc_ptr(grant_idx);
`endif
    end
  end

  assign regWrite      = wr_en;
  assign writeRegister = wr_addr;
  assign writeData     = wr_data;
  assign grantId       = gnt_id;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a per-cycle reference model.
module tb_regfile_write_arbiter;
  localparam int N  = 3;
  localparam int AW = 3;
  localparam int DW = 8;

  logic            clock = 1'b0;
  logic            resetN, hold;
  logic [N-1:0]    reqValid, reqLock, reqReady;
  logic [N*AW-1:0] reqAddr;
  logic [N*DW-1:0] reqData;
  logic            regWrite, busy;
  logic [AW-1:0]   writeRegister;
  logic [DW-1:0]   writeData;
  logic [1:0]      grantId;

  int n_cmp = 0;
  int n_err = 0;

  regfile_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .resetN(resetN), .hold(hold),
    .reqValid(reqValid), .reqAddr(reqAddr), .reqData(reqData), .reqLock(reqLock),
    .reqReady(reqReady), .regWrite(regWrite), .writeRegister(writeRegister),
    .writeData(writeData), .grantId(grantId), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who wins this cycle, and what the write port shows next cycle.
  int            m_ptr = 0, m_owner = 0, m_gid = 0, m_idx;
  bit            m_locked = 1'b0, m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [N-1:0]  exp_ready;

  function automatic int pick(input logic [N-1:0] v, input logic h, input logic rn,
                              input int p, input bit lk, input int ow);
    if (h !== 1'b0 || rn !== 1'b1) return -1;
    for (int k = 0; k < N; k++) begin
      int jj;
      jj = (p + k) % N;
      if (v[jj] && (!lk || jj == ow)) return jj;
    end
    return -1;
  endfunction

  always_comb begin
    m_idx     = pick(reqValid, hold, resetN, m_ptr, m_locked, m_owner);
    exp_ready = '0;
    if (m_idx >= 0) exp_ready[m_idx] = 1'b1;
  end

  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      m_ptr <= 0; m_we <= 1'b0; m_addr <= '0; m_data <= '0;
      m_gid <= 0; m_locked <= 1'b0; m_owner <= 0;
    end else begin
      m_we <= (m_idx >= 0);
      if (m_idx >= 0) begin
        m_addr <= reqAddr[m_idx*AW +: AW];
        m_data <= reqData[m_idx*DW +: DW];
        m_gid  <= m_idx;
      end
`ifdef REGFILE_ARB_LOCK_EN
      if (m_locked) begin
        if ((m_idx >= 0) ? !reqLock[m_idx] : !reqValid[m_owner]) begin
          m_locked <= 1'b0;
          m_ptr    <= (m_owner + 1) % N;
        end
      end else if (m_idx >= 0) begin
        if (reqLock[m_idx]) begin
          m_locked <= 1'b1;
          m_owner  <= m_idx;
        end else m_ptr <= (m_idx + 1) % N;
      end
`else
      if (m_idx >= 0) m_ptr <= (m_idx + 1) % N;
`endif
    end
  end

  always @(negedge clock) begin
    if (resetN === 1'b1) begin
      chk("model reqReady", reqReady, exp_ready);
      chk("model regWrite", regWrite, m_we);
      chk("model busy", busy, m_we | m_locked);
      chk("model writeRegister", writeRegister, m_addr);
      chk("model writeData", writeData, m_data);
      if (m_we) chk("model grantId", grantId, m_gid);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    reqValid[i]         = v;
    reqAddr[i*AW +: AW] = a;
    reqData[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    resetN   = 1'b0;
    reqValid = '0;
    reqLock  = '0;
    hold     = 1'b0;
    tick();
    resetN   = 1'b1;
  endtask

  initial begin
    resetN = 1'b1; hold = 1'b0; reqValid = '0; reqLock = '0; reqAddr = '0; reqData = '0;
    #1 resetN = 1'b0;
    tick(); tick();
    chk("reset regWrite", regWrite, 0);
    chk("reset writeRegister", writeRegister, 0);
    chk("reset writeData", writeData, 0);
    chk("reset grantId", grantId, 0);
    chk("reset busy", busy, 0);
    reqValid = 3'b111;
    #1 chk("reset reqReady", reqReady, 3'b000);
    reqValid = '0;
    resetN = 1'b1;

    // single requester 1
    set_req(1, 1'b1, 3'd5, 8'h3C);
    #1 chk("t1 ready", reqReady, 3'b010);
    tick();
    set_req(1, 1'b0, 3'd5, 8'h3C);
    chk("t1 regWrite", regWrite, 1);
    chk("t1 writeRegister", writeRegister, 5);
    chk("t1 writeData", writeData, 8'h3C);
    chk("t1 grantId", grantId, 1);
    reqValid = 3'b101;
    #1 chk("t1 rrPtr=2", reqReady, 3'b100);
    reqValid = '0;

    // all three continuously from rrPtr=0
    do_reset();
    set_req(0, 1'b1, 3'd1, 8'h11);
    set_req(1, 1'b1, 3'd2, 8'h22);
    set_req(2, 1'b1, 3'd3, 8'h33);
    #1 chk("t2 ready", reqReady, 3'b001);
    tick(); chk("t2 g0", grantId, 0); chk("t2 d0", writeData, 8'h11); chk("t2 we0", regWrite, 1);
    tick(); chk("t2 g1", grantId, 1); chk("t2 d1", writeData, 8'h22); chk("t2 we1", regWrite, 1);
    tick(); chk("t2 g2", grantId, 2); chk("t2 d2", writeData, 8'h33); chk("t2 we2", regWrite, 1);
    tick(); chk("t2 g3", grantId, 0); chk("t2 d3", writeData, 8'h11); chk("t2 we3", regWrite, 1);
    reqValid = '0;
    tick();
    chk("t2 idle regWrite", regWrite, 0);
    chk("t2 hold data", writeData, 8'h11);
    chk("t2 hold addr", writeRegister, 1);

    // hold blocks grants
    hold = 1'b1;
    set_req(0, 1'b1, 3'd6, 8'h5A);
    #1 chk("t3 ready held", reqReady, 3'b000);
    tick(); chk("t3 we c1", regWrite, 0);
    tick(); tick(); chk("t3 we c3", regWrite, 0); chk("t3 busy", busy, 0);
    hold = 1'b0;
    #1 chk("t3 ready release", reqReady, 3'b001);
    tick();
    set_req(0, 1'b0, 3'd6, 8'h5A);
    chk("t3 we", regWrite, 1); chk("t3 addr", writeRegister, 6);
    chk("t3 data", writeData, 8'h5A); chk("t3 gid", grantId, 0);

    // async reset mid-burst
    set_req(0, 1'b1, 3'd7, 8'hAA);
    tick();
    reqValid = '0;
    chk("t4 we before", regWrite, 1); chk("t4 data before", writeData, 8'hAA);
    #2 resetN = 1'b0;
    #1;
    chk("t4 async we", regWrite, 0); chk("t4 async data", writeData, 0);
    chk("t4 async addr", writeRegister, 0); chk("t4 async busy", busy, 0);
    tick();
    resetN = 1'b1;
    reqValid = 3'b111;
    #1 chk("t4 rrPtr=0", reqReady, 3'b001);
    reqValid = '0;

    // two requesters to the same register
    set_req(0, 1'b1, 3'd4, 8'h01);
    set_req(2, 1'b1, 3'd4, 8'h02);
    #1 chk("t5 ready", reqReady, 3'b001);
    tick();
    set_req(0, 1'b0, 3'd4, 8'h01);
    chk("t5 first gid", grantId, 0); chk("t5 first data", writeData, 8'h01); chk("t5 first addr", writeRegister, 4);
    tick();
    reqValid = '0;
    chk("t5 second gid", grantId, 2); chk("t5 second data", writeData, 8'h02); chk("t5 second we", regWrite, 1);
    tick();
    chk("t5 done we", regWrite, 0); chk("t5 final data", writeData, 8'h02);

    // move rrPtr to 2, then a lock burst from requester 2
    set_req(1, 1'b1, 3'd0, 8'h77);
    tick();
    reqValid = '0;
    set_req(0, 1'b1, 3'd1, 8'hA0);
    set_req(1, 1'b1, 3'd2, 8'hB1);
    set_req(2, 1'b1, 3'd3, 8'hC2);
    reqLock = 3'b100;
    #1 chk("t6 ready", reqReady, 3'b100);
    tick(); chk("t6 beat1 gid", grantId, 2);
`ifdef REGFILE_ARB_LOCK_EN
    chk("t6 locked ready", reqReady, 3'b100);
    tick(); chk("t6 beat2 gid", grantId, 2);
    reqLock = 3'b000;
    tick(); chk("t6 beat3 gid", grantId, 2); chk("t6 beat3 data", writeData, 8'hC2);
    chk("t6 unlock ready", reqReady, 3'b001);
    tick(); chk("t6 after gid", grantId, 0);
`else
    chk("t6 lock ignored ready", reqReady, 3'b001);
    tick(); chk("t6 rr gid", grantId, 0);
`endif
    reqValid = '0;
    reqLock  = '0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
